// File: rtl/draw_scheduler_pkg.sv
// draw_sched_pkg: shared definitions for the frame draw scheduler.
// Holds the FSM state encoding, the client index map and the default
// sizing constants used by the scheduler, its watchdog and its interface.
package draw_sched_pkg;

    // Scheduler FSM states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_NEXT   = 3'd4,
        S_FINISH = 3'd5
    } sched_state_t;

    // Client index map; a lower index is serviced earlier in the frame
    localparam int CLIENT_MAP     = 0;
    localparam int CLIENT_SPRITE0 = 1;
    localparam int CLIENT_SPRITE1 = 2;
    localparam int CLIENT_HUD     = 3;

    // Default sizing; the timeout must exceed a full 160x120 redraw by
    // the slowest client (4 cycles per pixel)
    localparam int DEFAULT_NUM_CLIENTS    = 4;
    localparam int DEFAULT_TIMEOUT_W      = 18;
    localparam int DEFAULT_TIMEOUT_CYCLES = 131071;

endpackage

// File: rtl/draw_scheduler_if.sv
// draw_sched_if: control bundle between the draw scheduler and its clients.
// master modport: the scheduler (drives draw pulses, grants, status flags).
// slave modport : the clients / frame timing logic (drive frame_start,
//                 enable mask, done pulses and err_clear).
interface draw_sched_if #(
    parameter int NUM_CLIENTS = draw_sched_pkg::DEFAULT_NUM_CLIENTS
);
    localparam int CUR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    logic                   frame_start;
    logic [NUM_CLIENTS-1:0] client_enable;
    logic [NUM_CLIENTS-1:0] client_done;
    logic                   err_clear;
    logic [NUM_CLIENTS-1:0] client_draw;
    logic [NUM_CLIENTS-1:0] grant;
    logic [CUR_W-1:0]       cur_client;
    logic                   busy;
    logic                   frame_done;
    logic                   timeout_err;
    logic                   overrun_err;

    modport master (
        input  frame_start, client_enable, client_done, err_clear,
        output client_draw, grant, cur_client, busy, frame_done,
               timeout_err, overrun_err
    );

    modport slave (
        output frame_start, client_enable, client_done, err_clear,
        input  client_draw, grant, cur_client, busy, frame_done,
               timeout_err, overrun_err
    );

endinterface

// File: rtl/draw_scheduler_watchdog.sv
// sched_watchdog: saturating cycle counter guarding a client's WAIT phase.
// Ports:
//   clk, resetn : clock and asynchronous active-low reset
//   clear       : synchronous clear to zero (has priority over enable)
//   enable      : count one cycle
//   expired     : count has reached LIMIT-1
module sched_watchdog #(
    parameter int W     = draw_sched_pkg::DEFAULT_TIMEOUT_W,
    parameter int LIMIT = draw_sched_pkg::DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [W-1:0] count;

    // Counter stops at all-ones so a stuck enable can never wrap it back
    // below the expiry threshold.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == W'(LIMIT - 1));

endmodule

// File: rtl/draw_scheduler.sv
// draw_scheduler: serialises the frame-drawing clients onto the shared
// pixel and ROM address buses. On each accepted frame_start every enabled
// client is started in index order; its grant is held until its done
// pulse (or a watchdog timeout), followed by a one-cycle all-zero grant
// turnaround before the next client.
// Ports:
//   clk, resetn : clock and asynchronous active-low reset
//   bus         : draw_sched_if master modport (frame_start, client_enable,
//                 client_done, err_clear in; client_draw, grant, cur_client,
//                 busy, frame_done, timeout_err, overrun_err out)
module draw_scheduler
    import draw_sched_pkg::*;
#(
    parameter int NUM_CLIENTS    = DEFAULT_NUM_CLIENTS,
    parameter int TIMEOUT_W      = DEFAULT_TIMEOUT_W,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic         clk,
    input  logic         resetn,
    draw_sched_if.master bus
);

    // idx must be able to hold NUM_CLIENTS itself to mark end of scan
    localparam int IDX_W = $clog2(NUM_CLIENTS + 1);
    localparam int CUR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    sched_state_t           state;
    sched_state_t           state_nxt;
    logic [IDX_W-1:0]       idx;
    logic [CUR_W-1:0]       cur_idx;
    logic [NUM_CLIENTS-1:0] pending;
    logic [NUM_CLIENTS-1:0] sel_onehot;
    logic                   scan_end;
    logic                   done_sel;
    logic                   wd_expired;
    logic                   timeout_set;
    logic                   overrun_set;
    logic                   timeout_err_q;
    logic                   overrun_err_q;

    logic [NUM_CLIENTS-1:0] client_draw;
    logic [NUM_CLIENTS-1:0] grant;
    logic                   busy;
    logic                   frame_done;

    assign cur_idx    = idx[CUR_W-1:0];
    assign scan_end   = (idx == IDX_W'(NUM_CLIENTS));
    assign sel_onehot = NUM_CLIENTS'(1) << cur_idx;
    // Only the selected client's done counts; others are noise here
    assign done_sel   = bus.client_done[cur_idx];

    // Done takes priority over an expiry in the same cycle
    assign timeout_set = (state == S_WAIT) && wd_expired && !done_sel;
    assign overrun_set = bus.frame_start && (state != S_IDLE);

    sched_watchdog #(
        .W     (TIMEOUT_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (state == S_START),
        .enable  (state == S_WAIT),
        .expired (wd_expired)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Client index, latched enable mask and sticky error flags. The mask
    // is captured only on acceptance so mid-frame enable changes are ignored.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx           <= '0;
            pending       <= '0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.frame_start) begin
                        pending <= bus.client_enable;
                        idx     <= '0;
                    end
                end
                S_SCAN: begin
                    if (!scan_end && !pending[cur_idx]) begin
                        idx <= idx + 1'b1;
                    end
                end
                S_NEXT: begin
                    idx <= idx + 1'b1;
                end
                default: begin
                end
            endcase

            // Setting beats clearing when both happen together
            if (timeout_set) begin
                timeout_err_q <= 1'b1;
            end else if (bus.err_clear) begin
                timeout_err_q <= 1'b0;
            end

            if (overrun_set) begin
                overrun_err_q <= 1'b1;
            end else if (bus.err_clear) begin
                overrun_err_q <= 1'b0;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.frame_start) state_nxt = S_SCAN;
            S_SCAN: begin
                if (scan_end) begin
                    state_nxt = S_FINISH;
                end else if (pending[cur_idx]) begin
                    state_nxt = S_START;
                end
            end
            S_START:  state_nxt = S_WAIT;
            S_WAIT:   if (done_sel || wd_expired) state_nxt = S_NEXT;
            S_NEXT:   state_nxt = S_SCAN;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs decode from registered state only, so no input reaches an
    // output combinationally and reset drops grant immediately.
    always_comb begin
        client_draw = '0;
        grant       = '0;
        busy        = 1'b0;
        frame_done  = 1'b0;
        case (state)
            S_SCAN:   busy = 1'b1;
            S_START: begin
                client_draw = sel_onehot;
                grant       = sel_onehot;
                busy        = 1'b1;
            end
            S_WAIT: begin
                grant = sel_onehot;
                busy  = 1'b1;
            end
            S_NEXT:   busy = 1'b1;
            S_FINISH: begin
                frame_done = 1'b1;
                busy       = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.client_draw = client_draw;
    assign bus.grant       = grant;
    assign bus.cur_client  = cur_idx;
    assign bus.busy        = busy;
    assign bus.frame_done  = frame_done;
    assign bus.timeout_err = timeout_err_q;
    assign bus.overrun_err = overrun_err_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler: directed bench for draw_scheduler. Two instances share
// one set of inputs: dut uses a long timeout for the normal-traffic steps,
// dut_wd uses a 20-cycle timeout for the watchdog steps. Step counters n/s
// below are the number of rising edges since frame_start was sampled; all
// sampling is 1 time unit after a rising edge.
module tb_draw_scheduler;

    logic clk;
    logic resetn;
    int   total;
    int   bad;

    draw_sched_if #(.NUM_CLIENTS(4)) bus ();
    draw_sched_if #(.NUM_CLIENTS(4)) bus2 ();

    assign bus2.frame_start   = bus.frame_start;
    assign bus2.client_enable = bus.client_enable;
    assign bus2.client_done   = bus.client_done;
    assign bus2.err_clear     = bus.err_clear;

    draw_scheduler #(
        .NUM_CLIENTS    (4),
        .TIMEOUT_W      (18),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    draw_scheduler #(
        .NUM_CLIENTS    (4),
        .TIMEOUT_W      (18),
        .TIMEOUT_CYCLES (20)
    ) dut_wd (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Pulse frame_start for one edge with the given enable mask
    task automatic apply_stimulus(input logic [3:0] en);
        bus.frame_start   = 1'b1;
        bus.client_enable = en;
        tick();
        bus.frame_start = 1'b0;
    endtask

    initial begin
        int misses;
        int draws;
        int d1_step, d2_step, fd_step, fd_count, gap, overlap, done_at;
        int hold, to_step, d3_step;
        logic [3:0] d1_val, d2_val, done_val;

        total = 0;
        bad   = 0;
        resetn = 1'b0;
        bus.frame_start   = 1'b0;
        bus.client_enable = 4'b0000;
        bus.client_done   = 4'b0000;
        bus.err_clear     = 1'b0;

        // Power-on reset
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        tick();
        check_output("reset_outputs", 32'({bus.grant, bus.client_draw, bus.cur_client,
                     bus.busy, bus.frame_done, bus.timeout_err, bus.overrun_err}), 32'd0);

        // Asynchronous reset while client 2 is in WAIT
        apply_stimulus(4'b0100);                    // n=0 SCAN idx0
        repeat (4) tick();                          // n=4 WAIT on client 2
        check_output("rst_grant_before", 32'(bus.grant), 32'h4);
        #3 resetn = 1'b0;
        #1;
        check_output("rst_async_grant", 32'(bus.grant), 32'h0);
        check_output("rst_async_busy", 32'(bus.busy), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2 resetn = 1'b1;
        tick();
        check_output("rst_release_outputs", 32'({bus.grant, bus.client_draw, bus.cur_client,
                     bus.busy, bus.frame_done, bus.timeout_err, bus.overrun_err}), 32'd0);

        // Single client 0, done 50 edges after its draw pulse; a stray
        // done from client 1 mid-WAIT must be ignored
        apply_stimulus(4'b0001);                    // n=0
        check_output("t1_busy_scan", 32'(bus.busy), 32'h1);
        check_output("t1_no_early_draw", 32'(bus.client_draw), 32'h0);
        tick();                                     // n=1 START
        check_output("t1_draw", 32'(bus.client_draw), 32'h1);
        check_output("t1_grant_start", 32'(bus.grant), 32'h1);
        check_output("t1_cur_client", 32'(bus.cur_client), 32'h0);
        tick();                                     // n=2 WAIT
        misses = 0;
        for (int n = 2; n < 50; n++) begin
            if (bus.grant !== 4'b0001) misses++;
            bus.client_done = (n == 20) ? 4'b0010 : 4'b0000;
            tick();
        end
        bus.client_done = 4'b0000;
        if (bus.grant !== 4'b0001) misses++;        // n=50, done cycle
        check_output("t1_grant_hold", 32'(misses), 32'd0);
        bus.client_done = 4'b0001;
        tick();                                     // n=51 NEXT
        bus.client_done = 4'b0000;
        check_output("t1_turnaround_grant", 32'(bus.grant), 32'h0);
        check_output("t1_turnaround_busy", 32'(bus.busy), 32'h1);
        misses = 0;
        for (int n = 52; n <= 55; n++) begin
            tick();
            if (bus.frame_done !== 1'b0) misses++;
        end
        check_output("t1_no_early_done", 32'(misses), 32'd0);
        tick();                                     // n=56 FINISH
        check_output("t1_frame_done", 32'(bus.frame_done), 32'h1);
        tick();                                     // n=57 IDLE
        check_output("t1_idle_busy", 32'(bus.busy), 32'h0);
        check_output("t1_no_overrun", 32'(bus.overrun_err), 32'h0);

        // Empty mask: frame_done after four scan steps, no draws
        apply_stimulus(4'b0000);                    // n=0
        misses = 0;
        for (int n = 1; n <= 4; n++) begin
            tick();
            if (bus.client_draw !== 4'b0000 || bus.frame_done !== 1'b0) misses++;
        end
        check_output("t2_quiet_scan", 32'(misses), 32'd0);
        tick();                                     // n=5 FINISH
        check_output("t2_frame_done", 32'(bus.frame_done), 32'h1);

        // Clients 1 and 3, each done 10 edges after its draw.
        // Expected: draw 1 at n=2, NEXT at 13, SCAN 14..15, draw 3 at 16,
        // NEXT at 27, SCAN 28, FINISH at 29.
        tick();
        apply_stimulus(4'b1010);
        draws = 0; d1_step = -1; d2_step = -1; fd_step = -1; fd_count = 0;
        gap = 0; overlap = 0; done_at = -100;
        d1_val = 4'b0; d2_val = 4'b0; done_val = 4'b0;
        for (int s = 0; s < 40; s++) begin
            if (bus.client_draw !== 4'b0000) begin
                draws++;
                if (draws == 1) begin
                    d1_step = s; d1_val = bus.client_draw;
                end else begin
                    d2_step = s; d2_val = bus.client_draw;
                end
                done_at  = s + 10;
                done_val = bus.client_draw;
            end
            if ($countones(bus.grant) > 1) overlap++;
            if (draws == 1 && bus.grant === 4'b0000) gap++;
            if (bus.frame_done === 1'b1) begin
                fd_count++;
                fd_step = s;
            end
            bus.client_done = (s == done_at) ? done_val : 4'b0000;
            tick();
        end
        bus.client_done = 4'b0000;
        check_output("t3_draw_count", 32'(draws), 32'd2);
        check_output("t3_draw1_step", 32'(d1_step), 32'd2);
        check_output("t3_draw1_val", 32'(d1_val), 32'h2);
        check_output("t3_draw2_step", 32'(d2_step), 32'd16);
        check_output("t3_draw2_val", 32'(d2_val), 32'h8);
        check_output("t3_overlap", 32'(overlap), 32'd0);
        check_output("t3_gap", 32'(gap), 32'd3);
        check_output("t3_fd_count", 32'(fd_count), 32'd1);
        check_output("t3_fd_step", 32'(fd_step), 32'd29);

        // Overrun: frame_start during WAIT and during FINISH is dropped
        apply_stimulus(4'b0001);                    // n=0
        repeat (3) tick();                          // n=3 WAIT
        bus.frame_start   = 1'b1;
        bus.client_enable = 4'b1111;
        tick();                                     // n=4
        bus.frame_start   = 1'b0;
        bus.client_enable = 4'b0001;
        check_output("t4_overrun_wait", 32'(bus.overrun_err), 32'h1);
        check_output("t4_grant_kept", 32'(bus.grant), 32'h1);
        bus.err_clear = 1'b1;
        tick();                                     // n=5
        bus.err_clear = 1'b0;
        check_output("t4_err_clear", 32'(bus.overrun_err), 32'h0);
        bus.client_done = 4'b0001;
        tick();                                     // n=6 NEXT
        bus.client_done = 4'b0000;
        misses = 0;
        for (int n = 7; n <= 10; n++) begin
            tick();
            if (bus.client_draw !== 4'b0000) misses++;
        end
        check_output("t4_mask_unchanged", 32'(misses), 32'd0);
        tick();                                     // n=11 FINISH
        check_output("t4_frame_done", 32'(bus.frame_done), 32'h1);
        bus.frame_start = 1'b1;
        tick();                                     // n=12 IDLE
        bus.frame_start = 1'b0;
        check_output("t4_finish_dropped", 32'(bus.busy), 32'h0);
        check_output("t4_overrun_finish", 32'(bus.overrun_err), 32'h1);
        bus.err_clear = 1'b1;
        tick();
        bus.err_clear = 1'b0;

        // Watchdog on dut_wd (limit 20): client 2 silent, client 3 done.
        // START c2 at n=3, WAIT 4..23, timeout_err at 24, draw c3 at 26,
        // done sampled at edge 28, FINISH at 30.
        check_output("t5_pre_clear", 32'(bus2.timeout_err), 32'h0);
        apply_stimulus(4'b1100);
        hold = 0; to_step = -1; d3_step = -1; fd_step = -1;
        for (int s = 0; s < 40; s++) begin
            if (bus2.grant === 4'b0100) hold++;
            if (bus2.timeout_err === 1'b1 && to_step < 0) to_step = s;
            if (bus2.client_draw === 4'b1000) d3_step = s;
            if (bus2.frame_done === 1'b1) fd_step = s;
            bus.client_done = (s == 27) ? 4'b1000 : 4'b0000;
            tick();
        end
        bus.client_done = 4'b0000;
        check_output("t5_grant2_hold", 32'(hold), 32'd21);
        check_output("t5_timeout_step", 32'(to_step), 32'd24);
        check_output("t5_client3_draw", 32'(d3_step), 32'd26);
        check_output("t5_frame_done", 32'(fd_step), 32'd30);
        check_output("t5_sticky", 32'(bus2.timeout_err), 32'h1);
        bus.err_clear = 1'b1;
        tick();
        bus.err_clear = 1'b0;
        check_output("t5_cleared", 32'(bus2.timeout_err), 32'h0);

        // Done arriving in the expiry cycle wins: no timeout_err
        apply_stimulus(4'b0100);                    // s=0
        repeat (23) tick();                         // s=23, timer at limit-1
        bus.client_done = 4'b0100;
        tick();                                     // s=24 NEXT
        bus.client_done = 4'b0000;
        check_output("t6_done_wins_err", 32'(bus2.timeout_err), 32'h0);
        check_output("t6_done_wins_grant", 32'(bus2.grant), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
